uart_tx_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares the single 40 kHz UART transmitter among N_REQ byte sources. It takes requests, latches the winner's byte, and issues the one-cycle `send_start` pulse to the transmitter. The transmitter has no busy flag, so this block times each frame itself and blocks new grants until the serial frame and a guard gap have fully elapsed. It sits between the application producers and the transmitter's `din`/`send_start` inputs.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the arbiter that feeds it,
// so that both sides derive their frame timing from the same numbers.
package uart_pkg;

   localparam int SYS_CLK_DEF = 40_000;
   localparam int BPS_DEF     = 1000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   function automatic int bps_cnt(input int sys_clk, input int bps);
      return sys_clk / bps;
   endfunction

   // One start bit, eight data bits, one stop bit, then the idle guard bits.
   function automatic int frame_cyc(input int sys_clk, input int bps, input int gap_bits);
      return (10 + gap_bits) * bps_cnt(sys_clk, bps);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request found searching
// upward from i_ptr, wrapping modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_ptr,
   output logic                     o_valid,
   output logic [$clog2(N_REQ)-1:0] o_idx
);

   localparam int IDX_W = $clog2(N_REQ);

   int w_idx;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = (int'(i_ptr) + k) % N_REQ;
         if (!o_valid && i_req[w_idx]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame sequencer for the shared UART transmitter. The transmitter
// has no busy flag, so each grant owns a fixed slot of FRAME_CYC cycles.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int SYS_CLK  = SYS_CLK_DEF,
   parameter int BPS      = BPS_DEF,
   parameter int GAP_BITS = 1
) (
   input  logic                     clk_40k,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [8*N_REQ-1:0]       i_data,
   output logic [N_REQ-1:0]         o_ack,
   output logic [N_REQ-1:0]         o_done,
   output logic [7:0]               o_tx_din,
   output logic                     o_tx_start,
   output logic                     o_busy,
   output logic [$clog2(N_REQ)-1:0] o_grant_id
);

   localparam int IDX_W     = $clog2(N_REQ);
   localparam int FRAME_CYC = frame_cyc(SYS_CLK, BPS, GAP_BITS);
   localparam int CNT_W     = $clog2(FRAME_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);

   if (SYS_CLK % BPS != 0) begin : g_bad_div
      $error("SYS_CLK must be an integer multiple of BPS");
   end
   if (FRAME_CYC >= 65536) begin : g_bad_frame
      $error("FRAME_CYC must be below 2^16");
   end
   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("N_REQ must be in 2..8");
   end

   arb_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0] r_gid, w_gid_nxt;
   logic [N_REQ-1:0] r_ack, w_ack_nxt;
   logic [N_REQ-1:0] r_done, w_done_nxt;
   logic [7:0]       r_tx_din, w_tx_din_nxt;
   logic             r_tx_start, w_tx_start_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_valid;
   logic [IDX_W-1:0] w_win;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_valid (w_valid),
      .o_idx   (w_win)
   );

   always_ff @(posedge clk_40k or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_gid      <= '0;
         r_ack      <= '0;
         r_done     <= '0;
         r_tx_din   <= 8'h00;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
         r_gid      <= w_gid_nxt;
         r_ack      <= w_ack_nxt;
         r_done     <= w_done_nxt;
         r_tx_din   <= w_tx_din_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   // ack/done/tx_start are pulses: they default low and are raised for one cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_ptr_nxt      = r_ptr;
      w_gid_nxt      = r_gid;
      w_ack_nxt      = '0;
      w_done_nxt     = '0;
      w_tx_din_nxt   = r_tx_din;
      w_tx_start_nxt = 1'b0;
      w_busy_nxt     = r_busy;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_tx_din_nxt     = i_data[8*int'(w_win) +: 8];
               w_ack_nxt[w_win] = 1'b1;
               w_gid_nxt        = w_win;
               w_busy_nxt       = 1'b1;
               w_state_nxt      = START;
            end
         end
         START: begin
            w_tx_start_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = WAIT;
         end
         WAIT: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
               w_done_nxt[r_gid] = 1'b1;
               w_busy_nxt        = 1'b0;
               w_cnt_nxt         = '0;
               w_ptr_nxt         = (r_gid == IDX_W'(N_REQ - 1)) ? '0 : r_gid + IDX_W'(1);
               w_state_nxt       = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_ack      = r_ack;
   assign o_done     = r_done;
   assign o_tx_din   = r_tx_din;
   assign o_tx_start = r_tx_start;
   assign o_busy     = r_busy;
   assign o_grant_id = r_gid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of single grants plus hand-written
// reset, contention and mid-frame reset sequences.
module tb_uart_tx_arbiter;

   localparam int FRAME = 440;
   localparam int PITCH = 442;

   logic        clk_40k;
   logic        rst_n;
   logic [3:0]  i_req;
   logic [31:0] i_data;
   logic [3:0]  o_ack;
   logic [3:0]  o_done;
   logic [7:0]  o_tx_din;
   logic        o_tx_start;
   logic        o_busy;
   logic [1:0]  o_grant_id;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] rq;
      int         g;
   } vec_t;

   vec_t       tbl[7];
   logic [7:0] src_byte[4];

   uart_tx_arbiter #(
      .N_REQ    (4),
      .SYS_CLK  (40_000),
      .BPS      (1000),
      .GAP_BITS (1)
   ) dut (
      .clk_40k    (clk_40k),
      .rst_n      (rst_n),
      .i_req      (i_req),
      .i_data     (i_data),
      .o_ack      (o_ack),
      .o_done     (o_done),
      .o_tx_din   (o_tx_din),
      .o_tx_start (o_tx_start),
      .o_busy     (o_busy),
      .o_grant_id (o_grant_id)
   );

   initial clk_40k = 1'b0;
   always #5 clk_40k = ~clk_40k;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".ack"}, 32'(o_ack), 0);
      chk({nm, ".done"}, 32'(o_done), 0);
      chk({nm, ".tx_din"}, 32'(o_tx_din), 0);
      chk({nm, ".tx_start"}, 32'(o_tx_start), 0);
      chk({nm, ".busy"}, 32'(o_busy), 0);
      chk({nm, ".grant_id"}, 32'(o_grant_id), 0);
   endtask

   // Called at a negedge while the arbiter is idle; returns at the done negedge.
   task automatic serve(input logic [3:0] rq, input int g, input string nm);
      int t;
      int extra;
      bit seen;
      i_req = rq;
      @(negedge clk_40k);
      chk({nm, ".ack"}, 32'(o_ack), 32'(1) << g);
      chk({nm, ".done_clear"}, 32'(o_done), 0);
      chk({nm, ".gid"}, 32'(o_grant_id), 32'(g));
      chk({nm, ".din"}, 32'(o_tx_din), 32'(src_byte[g]));
      chk({nm, ".busy"}, 32'(o_busy), 1);
      i_req = 4'b0000;
      @(negedge clk_40k);
      chk({nm, ".tx_start"}, 32'(o_tx_start), 1);
      chk({nm, ".ack_clear"}, 32'(o_ack), 0);
      t = 0;
      extra = 0;
      seen = 1'b0;
      while (!seen && t < 600) begin
         @(negedge clk_40k);
         t++;
         if (o_tx_start) extra++;
         if (o_done != 4'b0000) seen = 1'b1;
      end
      chk({nm, ".done_latency"}, 32'(t), 32'(FRAME));
      chk({nm, ".done"}, 32'(o_done), 32'(1) << g);
      chk({nm, ".busy_end"}, 32'(o_busy), 0);
      chk({nm, ".extra_start"}, 32'(extra), 0);
   endtask

   initial begin
      int cyc;
      int last;
      int w;
      bit seen;

      src_byte[0] = 8'hC3;
      src_byte[1] = 8'h5A;
      src_byte[2] = 8'hA5;
      src_byte[3] = 8'h3C;
      tbl[0] = '{4'b0010, 1};
      tbl[1] = '{4'b1010, 3};
      tbl[2] = '{4'b0100, 2};
      tbl[3] = '{4'b0011, 0};
      tbl[4] = '{4'b1001, 3};
      tbl[5] = '{4'b1111, 0};
      tbl[6] = '{4'b1100, 2};

      rst_n  = 1'b0;
      i_req  = 4'hF;
      i_data = {src_byte[3], src_byte[2], src_byte[1], src_byte[0]};

      // Reset held with all requests asserted
      repeat (4) @(negedge clk_40k);
      chk_all_zero("rst_hold");

      // Contention: all sources request continuously
      rst_n = 1'b1;
      @(negedge clk_40k);
      chk("first.ack", 32'(o_ack), 32'h1);
      chk("first.gid", 32'(o_grant_id), 0);
      cyc = 0;
      last = 0;
      for (int n = 0; n < 5; n++) begin
         w = 0;
         while (!o_tx_start && w < 600) begin
            @(negedge clk_40k);
            cyc++;
            w++;
         end
         chk("cont.start_seen", 32'(o_tx_start), 1);
         chk("cont.gid", 32'(o_grant_id), 32'(n % 4));
         chk("cont.din", 32'(o_tx_din), 32'(src_byte[n % 4]));
         if (n > 0) chk("cont.spacing", 32'(cyc - last), 32'(PITCH));
         last = cyc;
         if (n == 4) i_req = 4'b0000;
         @(negedge clk_40k);
         cyc++;
      end
      w = 0;
      seen = 1'b0;
      while (!seen && w < 600) begin
         @(negedge clk_40k);
         w++;
         if (o_done != 4'b0000) seen = 1'b1;
      end
      chk("cont.done", 32'(o_done), 32'h1);

      // Table of grants, each request raised in the done cycle of the previous one
      for (int i = 0; i < 7; i++) begin
         serve(tbl[i].rq, tbl[i].g, $sformatf("vec%0d", i));
      end

      // Reset in the middle of a frame slot
      i_req = 4'b0001;
      @(negedge clk_40k);
      chk("midrst.ack", 32'(o_ack), 32'h1);
      i_req = 4'b0000;
      @(negedge clk_40k);
      chk("midrst.tx_start", 32'(o_tx_start), 1);
      repeat (200) @(negedge clk_40k);
      chk("midrst.busy_before", 32'(o_busy), 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk_40k);
      rst_n = 1'b1;
      i_req = 4'b1010;
      @(negedge clk_40k);
      chk("postrst.ack", 32'(o_ack), 32'h2);
      chk("postrst.gid", 32'(o_grant_id), 1);
      chk("postrst.din", 32'(o_tx_din), 32'(src_byte[1]));
      i_req = 4'b0000;
      @(negedge clk_40k);
      chk("postrst.tx_start", 32'(o_tx_start), 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
